// File: rtl/uart_io_port.sv
// uart_io_port: IO-bus responder with TX/RX byte FIFOs and an 8N1 UART.
// Optional macro UART_STATUS_REG_EN maps sticky error flags and a status register at port 0x04.
module uart_io_port #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  input  logic       uart_rx,
  output logic       uart_tx
);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_t;

  // Strobe edge detect: side effects fire once per strobe assertion.
  logic wr_q, rd_q, wr_edge, rd_edge;
  always_ff @(posedge clk100 or posedge reset)
    if (reset) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= IO_write_strobe;
      rd_q <= IO_read_strobe;
    end
  assign wr_edge = IO_write_strobe & ~wr_q;
  assign rd_edge = IO_read_strobe & ~rd_q;

  // TX FIFO
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wptr, tx_rptr;
  logic         tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]   tx_head;
  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[TAW] != tx_rptr[TAW]) && (tx_wptr[TAW-1:0] == tx_rptr[TAW-1:0]);
  assign tx_push  = wr_edge && (IO_port_ID == 8'h01) && !tx_full;
  assign tx_head  = tx_mem[tx_rptr[TAW-1:0]];

  always_ff @(posedge clk100)
    if (tx_push) tx_mem[tx_wptr[TAW-1:0]] <= IO_write_data;

  always_ff @(posedge clk100 or posedge reset)
    if (reset) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
    end

  // TX serialiser; uart_tx is registered so it is glitch-free and resets high at once.
  uart_st_t      tx_st, tx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_n;

  always_ff @(posedge clk100 or posedge reset)
    if (reset) begin
      tx_st   <= IDLE;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
      uart_tx <= 1'b1;
    end else begin
      tx_st   <= tx_st_n;
      tx_cnt  <= tx_cnt_n;
      tx_bit  <= tx_bit_n;
      tx_sh   <= tx_sh_n;
      uart_tx <= tx_n;
    end

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt + 1'b1;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_n     = uart_tx;
    tx_pop   = 1'b0;
    case (tx_st)
      IDLE: begin
        tx_cnt_n = '0;
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          tx_sh_n = tx_head;
          tx_st_n = START;
          tx_n    = 1'b0;
        end
      end
      START:
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          tx_bit_n = '0;
          tx_st_n  = DATA;
          tx_n     = tx_sh[0];
        end
      DATA:
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_st_n = STOP;
            tx_n    = 1'b1;
          end else begin
            tx_bit_n = tx_bit + 1'b1;
            tx_sh_n  = tx_sh >> 1;
            tx_n     = tx_sh[1];
          end
        end
      STOP:
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          // Back-to-back frames: next start bit follows the stop bit directly.
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            tx_sh_n = tx_head;
            tx_st_n = START;
            tx_n    = 1'b0;
          end else begin
            tx_st_n = IDLE;
          end
        end
      default: tx_st_n = IDLE;
    endcase
  end

  // RX synchroniser, reset to the idle-high line level.
  logic [1:0] rx_sync;
  logic       rx_s;
  always_ff @(posedge clk100 or posedge reset)
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], uart_rx};
  assign rx_s = rx_sync[1];

  uart_st_t      rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_done;

  always_ff @(posedge clk100 or posedge reset)
    if (reset) begin
      rx_st  <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt + 1'b1;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_done  = 1'b0;
    case (rx_st)
      IDLE: begin
        rx_cnt_n = '0;
        if (!rx_s) rx_st_n = START;
      end
      START:
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_st_n  = rx_s ? IDLE : DATA;
        end
      DATA:
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_st_n = STOP;
          else                rx_bit_n = rx_bit + 1'b1;
        end
      STOP:
        if (rx_cnt == CNT_LAST) begin
          rx_st_n = IDLE;
          rx_done = rx_s;
        end
      default: rx_st_n = IDLE;
    endcase
  end

  // RX FIFO; a same-cycle pop makes room for a push into a full FIFO.
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wptr, rx_rptr;
  logic         rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0]   rx_head;
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[RAW] != rx_rptr[RAW]) && (rx_wptr[RAW-1:0] == rx_rptr[RAW-1:0]);
  assign rx_pop   = rd_edge && (IO_port_ID == 8'h01) && !rx_empty;
  assign rx_push  = rx_done && (!rx_full || rx_pop);
  assign rx_head  = rx_mem[rx_rptr[RAW-1:0]];

  always_ff @(posedge clk100)
    if (rx_push) rx_mem[rx_wptr[RAW-1:0]] <= rx_sh;

  always_ff @(posedge clk100 or posedge reset)
    if (reset) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
    end

`ifdef UART_STATUS_REG_EN
  logic       overrun, framing_err, frame_ev, ovr_ev, stat_clr;
  logic [7:0] status;
  assign frame_ev = (rx_st == STOP) && (rx_cnt == CNT_LAST) && !rx_s;
  assign ovr_ev   = rx_done && rx_full && !rx_pop;
  assign stat_clr = rd_edge && (IO_port_ID == 8'h04);

  // A flag event in the clearing cycle wins over the clear.
  always_ff @(posedge clk100 or posedge reset)
    if (reset) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (ovr_ev)        overrun <= 1'b1;
      else if (stat_clr) overrun <= 1'b0;
      if (frame_ev)      framing_err <= 1'b1;
      else if (stat_clr) framing_err <= 1'b0;
    end

  assign status = {overrun, framing_err, rx_st != IDLE, tx_st != IDLE,
                   rx_full, !rx_empty, tx_full, tx_empty};
`endif

  always_comb begin
    IO_read_data = 8'h00;
    if (IO_read_strobe)
      case (IO_port_ID)
        8'h01:   IO_read_data = rx_empty ? 8'h00 : rx_head;
        8'h02:   IO_read_data = rx_empty ? 8'h00 : 8'hFF;
        8'h03:   IO_read_data = tx_full  ? 8'hFF : 8'h00;
`ifdef UART_STATUS_REG_EN
        8'h04:   IO_read_data = status;
`endif
        default: IO_read_data = 8'hFF;
      endcase
  end

endmodule

// File: tb/tb_uart_io_port.sv
// tb_uart_io_port: directed checks of the IO port map, UART framing, FIFO limits and reset.
module tb_uart_io_port;
  localparam int CPB = 4;

  logic       clk100 = 1'b0;
  logic       reset, IO_write_strobe, IO_read_strobe, rx_drv, loopback, mon_en;
  logic [7:0] IO_port_ID, IO_write_data, IO_read_data, rd, mon_b;
  logic       uart_rx, uart_tx;
  int         checks = 0, failures = 0;
  logic [7:0] mon_q[$];
  bit         a5_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  assign uart_rx = loopback ? uart_tx : rx_drv;
  always #5 clk100 = ~clk100;

  uart_io_port #(.CLKS_PER_BIT(CPB), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk100(clk100), .reset(reset), .IO_port_ID(IO_port_ID), .IO_write_data(IO_write_data),
    .IO_write_strobe(IO_write_strobe), .IO_read_strobe(IO_read_strobe),
    .IO_read_data(IO_read_data), .uart_rx(uart_rx), .uart_tx(uart_tx));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic io_wr(input logic [7:0] port, input logic [7:0] data);
    @(negedge clk100);
    IO_port_ID = port; IO_write_data = data; IO_write_strobe = 1'b1;
    @(negedge clk100);
    IO_write_strobe = 1'b0;
  endtask

  task automatic io_rd(input logic [7:0] port, output logic [7:0] data);
    @(negedge clk100);
    IO_port_ID = port; IO_read_strobe = 1'b1;
    #1 data = IO_read_data;
    @(negedge clk100);
    IO_read_strobe = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] port, input logic [7:0] exp);
    logic [7:0] d;
    io_rd(port, d);
    chk(tag, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk100); rx_drv = 1'b0; repeat (CPB-1) @(negedge clk100);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk100); rx_drv = b[i]; repeat (CPB-1) @(negedge clk100);
    end
    @(negedge clk100); rx_drv = stop; repeat (CPB-1) @(negedge clk100);
    @(negedge clk100); rx_drv = 1'b1; repeat (2*CPB) @(negedge clk100);
  endtask

  // Bench-side UART receiver on uart_tx, sampling mid-bit.
  always begin
    @(negedge clk100);
    if (mon_en && uart_tx === 1'b0) begin
      repeat (CPB/2) @(negedge clk100);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk100);
        mon_b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk100);
      if (uart_tx === 1'b1) mon_q.push_back(mon_b);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; IO_port_ID = 8'h00; IO_write_data = 8'h00;
    IO_write_strobe = 1'b0; IO_read_strobe = 1'b0;
    rx_drv = 1'b1; loopback = 1'b0; mon_en = 1'b0;
    repeat (3) @(negedge clk100);
    chk("rst_tx_high", 8'(uart_tx), 8'h01);
    chk("rdata_no_strobe", IO_read_data, 8'h00);
    reset = 1'b0;
    rd_chk("rst_p1_empty", 8'h01, 8'h00);
    rd_chk("rst_p2", 8'h02, 8'h00);
    rd_chk("rst_p3", 8'h03, 8'h00);
    rd_chk("unmapped_00", 8'h00, 8'hFF);
`ifdef UART_STATUS_REG_EN
    rd_chk("rst_status", 8'h04, 8'h01);
`else
    rd_chk("p4_unmapped", 8'h04, 8'hFF);
`endif

    // Loopback of 0xA5
    loopback = 1'b1; mon_en = 1'b1;
    io_wr(8'h01, 8'hA5);
    chk("tx_idle_at_push", 8'(uart_tx), 8'h01);
    @(negedge clk100);
    chk("tx_start_bit", 8'(uart_tx), 8'h00);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk100);
      chk($sformatf("tx_a5_bit%0d", i), 8'(uart_tx), 8'(a5_bits[i]));
    end
    repeat (CPB) @(negedge clk100);
    chk("tx_stop_bit", 8'(uart_tx), 8'h01);
    repeat (20) @(negedge clk100);
    rd_chk("loop_p2_avail", 8'h02, 8'hFF);
    rd_chk("loop_p1_data", 8'h01, 8'hA5);
    rd_chk("loop_p2_empty", 8'h02, 8'h00);
    loopback = 1'b0;
    mon_q.delete();

    // TX FIFO fill while serialiser busy
    for (int k = 0; k < 16; k++) io_wr(8'h01, 8'(k));
    rd_chk("tx_not_full_16w", 8'h03, 8'h00);
    io_wr(8'h01, 8'h10);
    rd_chk("tx_full_17w", 8'h03, 8'hFF);
    io_wr(8'h01, 8'h11);
    repeat (720) @(negedge clk100);
    chk("tx_frame_count", 8'(mon_q.size()), 8'd17);
    for (int k = 0; k < 17; k++)
      chk($sformatf("tx_byte%0d", k), (k < mon_q.size()) ? mon_q[k] : 8'hEE, 8'(k));
    mon_en = 1'b0;

    // Held read strobe pops once
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    @(negedge clk100);
    IO_port_ID = 8'h01; IO_read_strobe = 1'b1;
    #1 rd = IO_read_data;
    chk("hold_first", rd, 8'h11);
    repeat (5) @(negedge clk100);
    IO_read_strobe = 1'b0;
    rd_chk("hold_second", 8'h01, 8'h22);
    rd_chk("hold_third", 8'h01, 8'h33);
    rd_chk("hold_drained", 8'h02, 8'h00);

    // RX overrun
    for (int k = 0; k < 17; k++) send_frame(8'(8'h40 + k), 1'b1);
`ifdef UART_STATUS_REG_EN
    rd_chk("status_overrun", 8'h04, 8'h8D);
    rd_chk("status_ovr_clr", 8'h04, 8'h0D);
`else
    rd_chk("p4_unmapped_ovr", 8'h04, 8'hFF);
`endif
    for (int k = 0; k < 16; k++) rd_chk($sformatf("rx_keep%0d", k), 8'h01, 8'(8'h40 + k));
    rd_chk("rx_17th_dropped", 8'h02, 8'h00);

    // Framing error and glitch
    send_frame(8'h5A, 1'b0);
    rd_chk("framing_no_push", 8'h02, 8'h00);
`ifdef UART_STATUS_REG_EN
    rd_chk("status_framing", 8'h04, 8'h41);
`else
    rd_chk("p4_unmapped_frm", 8'h04, 8'hFF);
`endif
    @(negedge clk100); rx_drv = 1'b0;
    @(negedge clk100); rx_drv = 1'b1;
    repeat (50) @(negedge clk100);
    rd_chk("glitch_no_frame", 8'h02, 8'h00);
`ifdef UART_STATUS_REG_EN
    rd_chk("status_glitch", 8'h04, 8'h01);
`endif

    // Reset during TX bit 3 of 0xC3 with RX data pending
    send_frame(8'h77, 1'b1);
    rd_chk("pre_reset_rx", 8'h02, 8'hFF);
    io_wr(8'h01, 8'hC3);
    repeat (17) @(negedge clk100);
    chk("tx_bit3_low", 8'(uart_tx), 8'h00);
    #2 reset = 1'b1;
    #1 chk("reset_tx_now", 8'(uart_tx), 8'h01);
    @(negedge clk100);
    reset = 1'b0;
    rd_chk("post_rst_p3", 8'h03, 8'h00);
    rd_chk("post_rst_p2", 8'h02, 8'h00);
    rd_chk("post_rst_p1", 8'h01, 8'h00);
    rd_chk("unmapped_7e", 8'h7E, 8'hFF);
`ifdef UART_STATUS_REG_EN
    rd_chk("post_rst_status", 8'h04, 8'h01);
`endif
    repeat (12*CPB) @(negedge clk100);
    chk("post_rst_tx_idle", 8'(uart_tx), 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
